// File: rtl/spinner_quad_gen.sv
// Signed relative motion to rate-limited 2-bit Gray quadrature for the spinner input.
// Pending motion sits in a saturating accumulator and drains one encoder step per timer tick.
module spinner_quad_gen #(
    parameter int unsigned POS_W    = 12,
    parameter int unsigned STEP_DIV = 1500
) (
    input  logic             clk_12m,
    input  logic             reset,
    input  logic             ce,
    input  logic             clear,
    input  logic             delta_valid,
    input  logic [POS_W-1:0] delta,
    output logic [1:0]       enc,
    output logic             step,
    output logic             dir,
    output logic             busy
);

    localparam int unsigned DivW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(STEP_DIV - 1);
    localparam logic signed [POS_W+1:0] PosMax = {3'b000, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W+1:0] PosMin = -PosMax;

    logic [POS_W-1:0]        pos_q, pos_d;
    logic [DivW-1:0]         div_q, div_d;
    logic [1:0]              enc_q, enc_d;
    logic                    step_q, step_d;
    logic                    dir_q, dir_d;
    logic                    tick, neg;
    logic signed [POS_W+1:0] adj, sum;

    always_comb begin
        neg  = pos_q[POS_W-1];
        tick = ce && (div_q == '0) && (pos_q != '0);
        adj  = '0;
        if (tick) begin
            adj = neg ? (POS_W+2)'(1) : '1;
        end
        sum = $signed({{2{pos_q[POS_W-1]}}, pos_q})
            + $signed({{2{delta[POS_W-1]}}, delta})
            + adj;

        div_d  = div_q;
        enc_d  = enc_q;
        step_d = 1'b0;
        dir_d  = dir_q;
        pos_d  = pos_q;

        if (ce) begin
            div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);

            if (tick) begin
                // Forward rotates 00->10->11->01, reverse is the mirror; one bit flips per step.
                enc_d  = neg ? {enc_q[0], ~enc_q[1]} : {~enc_q[0], enc_q[1]};
                dir_d  = neg;
                step_d = 1'b1;
                pos_d  = pos_q + adj[POS_W-1:0];
            end

            if (clear) begin
                pos_d = '0;
            end else if (delta_valid) begin
                if (sum > PosMax) begin
                    pos_d = PosMax[POS_W-1:0];
                end else if (sum < PosMin) begin
                    pos_d = PosMin[POS_W-1:0];
                end else begin
                    pos_d = sum[POS_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_12m or negedge reset) begin
        if (!reset) begin
            pos_q  <= '0;
            div_q  <= '0;
            enc_q  <= 2'b11;
            step_q <= 1'b0;
            dir_q  <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            div_q  <= div_d;
            enc_q  <= enc_d;
            step_q <= step_d;
            dir_q  <= dir_d;
        end
    end

    assign enc  = enc_q;
    assign step = step_q;
    assign dir  = dir_q;
    assign busy = |pos_q;

endmodule
